// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4-slot TDM receive path.
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Mirrors the transmit-side 4:1 selector: slot 0 feeds the highest lane.
  function automatic logic [SLOT_W-1:0] slot_to_lane(input logic [SLOT_W-1:0] slot);
    return SLOT_W'(NUM_SLOTS - 1) - slot;
  endfunction
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: clear, load-to-1 (sync word taken as slot 0) and wrapping increment.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot,
  output logic              tc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        slot <= '0;
    else if (clr)   slot <= '0;
    else if (load1) slot <= SLOT_W'(1);
    else if (inc)   slot <= slot + 1'b1;
  end

  assign tc = (slot == SLOT_W'(NUM_SLOTS - 1));
endmodule

// File: rtl/tdm_demux4.sv
// De-interleaves a 4-slot TDM word stream into one registered 4-word frame per frame_valid pulse.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  input  logic                     frame_sync,
  output logic [NUM_SLOTS*WIDTH-1:0] dout,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err
);
  state_e                              state;
  logic [SLOT_W-1:0]                   slot;
  logic                                tc;
  logic                                ctr_inc, ctr_load1, ctr_clr;
  logic                                cap_en, frame_done, miss_sync, early_sync;
  logic [SLOT_W-1:0]                   cap_slot;
  // Words for slots 0..2; the slot-3 word goes straight from din into dout.
  logic [NUM_SLOTS-2:0][WIDTH-1:0]     shadow;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctr_inc),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .slot  (slot),
    .tc    (tc)
  );

  always_comb begin
    ctr_inc    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_clr    = 1'b0;
    cap_en     = 1'b0;
    cap_slot   = '0;
    frame_done = 1'b0;
    miss_sync  = 1'b0;
    early_sync = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        // A sync word always restarts the frame, dropping any partial one.
        ctr_load1  = 1'b1;
        cap_en     = 1'b1;
        early_sync = (state == LOCKED) && (slot != '0);
      end else if (state == LOCKED) begin
        if (slot == '0) begin
          miss_sync = 1'b1;
          ctr_clr   = 1'b1;
        end else begin
          ctr_inc    = 1'b1;
          cap_en     = !tc;
          cap_slot   = slot;
          frame_done = tc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (cap_en) begin
      for (int s = 0; s < NUM_SLOTS - 1; s++)
        if (cap_slot == SLOT_W'(s)) shadow[s] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      sync_err    <= miss_sync | early_sync;
      if (frame_done) dout <= {din, shadow};
      if (din_valid && frame_sync) state <= LOCKED;
      else if (miss_sync)          state <= HUNT;
    end
  end

  assign locked = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus random traffic against a queue model.
module tb_tdm_demux4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] dout;
  logic           frame_valid;
  logic           locked;
  logic           sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words of the frame in progress, in arrival order.
  logic [W-1:0]   q[$];
  logic           m_lock;
  logic [4*W-1:0] m_dout;
  logic           m_fv, m_err;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_lock = 1'b0;
    m_dout = '0;
    m_fv   = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (s) begin
        if (m_lock && q.size() != 0) m_err = 1'b1;
        q.delete();
        q.push_back(d);
        m_lock = 1'b1;
      end else if (m_lock) begin
        if (q.size() == 0) begin
          m_err  = 1'b1;
          m_lock = 1'b0;
        end else begin
          q.push_back(d);
          if (q.size() == 4) begin
            m_dout = {q[3], q[2], q[1], q[0]};
            m_fv   = 1'b1;
            q.delete();
          end
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and advance the model; outputs are sampled 1ns after the edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    model_step(v, s, d);
  endtask

  task automatic test_reset();
    rst = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({frame_valid, sync_err, locked, dout} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset: fv=%b err=%b lk=%b dout=%h, want all 0", frame_valid, sync_err, locked, dout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hFF);
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {m_fv, m_err, m_lock, m_dout}) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: fv=%b err=%b lk=%b dout=%h, want %b %b %b %h",
                 i, frame_valid, sync_err, locked, dout, m_fv, m_err, m_lock, m_dout);
      end
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] w[4];
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, w[i]);
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {m_fv, m_err, m_lock, m_dout}) begin
        n_fail++;
        $display("FAIL lock[%0d]: fv=%b err=%b lk=%b dout=%h, want %b %b %b %h",
                 i, frame_valid, sync_err, locked, dout, m_fv, m_err, m_lock, m_dout);
      end
    end
    n_checks++;
    if ({frame_valid, locked, dout} !== {2'b11, 32'h44332211}) begin
      n_fail++;
      $display("FAIL lock_frame: fv=%b lk=%b dout=%h, want 1 1 44332211", frame_valid, locked, dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w[8];
    logic [3:0]   v[10];
    int           pulses = 0, k = 0;
    w = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h5A, 8'h6B, 8'h7C, 8'h8D};
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 3) begin
        step(1'b0, 1'b0, 8'h00);
      end else begin
        step(1'b1, (k % 4) == 0, w[k]);
        k++;
      end
      if (frame_valid === 1'b1) pulses++;
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {m_fv, m_err, m_lock, m_dout}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: fv=%b err=%b lk=%b dout=%h, want %b %b %b %h",
                 i, frame_valid, sync_err, locked, dout, m_fv, m_err, m_lock, m_dout);
      end
      if (i == 5) begin
        n_checks++;
        if (dout !== 32'hD4C3B2A1) begin
          n_fail++;
          $display("FAIL b2b_frame1: dout=%h, want d4c3b2a1", dout);
        end
      end
    end
    n_checks++;
    if (dout !== 32'h8D7C6B5A || pulses != 2) begin
      n_fail++;
      $display("FAIL b2b_frame2: dout=%h pulses=%0d, want 8d7c6b5a 2", dout, pulses);
    end
  endtask

  task automatic test_missing_sync();
    step(1'b1, 1'b0, 8'h99);
    n_checks++;
    if ({frame_valid, sync_err, locked, dout} !== {3'b010, 32'h8D7C6B5A}) begin
      n_fail++;
      $display("FAIL missing_sync: fv=%b err=%b lk=%b dout=%h, want 0 1 0 8d7c6b5a",
               frame_valid, sync_err, locked, dout);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'(8'h90 + i));
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {m_fv, m_err, m_lock, m_dout}) begin
        n_fail++;
        $display("FAIL missing_sync_hunt[%0d]: fv=%b err=%b lk=%b dout=%h, want %b %b %b %h",
                 i, frame_valid, sync_err, locked, dout, m_fv, m_err, m_lock, m_dout);
      end
    end
  endtask

  task automatic test_hunt_discard();
    logic [W-1:0] w[6];
    w = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i == 2, w[i]);
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {m_fv, m_err, m_lock, m_dout} || sync_err !== 1'b0) begin
        n_fail++;
        $display("FAIL hunt[%0d]: fv=%b err=%b lk=%b dout=%h, want %b %b %b %h",
                 i, frame_valid, sync_err, locked, dout, m_fv, m_err, m_lock, m_dout);
      end
    end
    n_checks++;
    if ({frame_valid, dout} !== {1'b1, 32'h04030201}) begin
      n_fail++;
      $display("FAIL hunt_frame: fv=%b dout=%h, want 1 04030201", frame_valid, dout);
    end
  endtask

  task automatic test_early_sync();
    logic [W-1:0] w[6];
    logic         s[6];
    int           errs = 0, pulses = 0;
    w = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, s[i], w[i]);
      if (sync_err === 1'b1) errs++;
      if (frame_valid === 1'b1) pulses++;
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {m_fv, m_err, m_lock, m_dout}) begin
        n_fail++;
        $display("FAIL early[%0d]: fv=%b err=%b lk=%b dout=%h, want %b %b %b %h",
                 i, frame_valid, sync_err, locked, dout, m_fv, m_err, m_lock, m_dout);
      end
    end
    n_checks++;
    if (dout !== 32'h60504030 || errs != 1 || pulses != 1) begin
      n_fail++;
      $display("FAIL early_summary: dout=%h errs=%0d pulses=%0d, want 60504030 1 1", dout, errs, pulses);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 8'hE0);
    step(1'b1, 1'b0, 8'hE1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({frame_valid, sync_err, locked, dout} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: fv=%b err=%b lk=%b dout=%h, want all 0", frame_valid, sync_err, locked, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'(8'hE2 + i));
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {3'b000, 32'h0}) begin
        n_fail++;
        $display("FAIL async_reset_after[%0d]: fv=%b err=%b lk=%b dout=%h, want all 0",
                 i, frame_valid, sync_err, locked, dout);
      end
    end
  endtask

  task automatic test_random();
    logic         v, s;
    logic [W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(3) != 0);
      if (m_lock && q.size() == 0) s = ($urandom_range(7) != 0);
      else                         s = ($urandom_range(7) == 0);
      d = W'($urandom);
      step(v, s, d);
      n_checks++;
      if ({frame_valid, sync_err, locked, dout} !== {m_fv, m_err, m_lock, m_dout}) begin
        n_fail++;
        $display("FAIL random[%0d]: fv=%b err=%b lk=%b dout=%h, want %b %b %b %h",
                 i, frame_valid, sync_err, locked, dout, m_fv, m_err, m_lock, m_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_back_to_back();
    test_missing_sync();
    test_hunt_discard();
    test_early_sync();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
